tile_bram_reader: RTL and testbench
===================================

TILE_BRAM_READER -- requirements
Module: tile_bram_reader

Interface
REQ-001 SHALL have parameter MAN_WIDTH, default 256, mantissa line width.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, exponent width.
REQ-003 SHALL have parameter BRAM_DEPTH, default 512, lines per tile BRAM side.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(BRAM_DEPTH), read address width.
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports i_cmd_valid input 1, o_cmd_ready output 1: command handshake.
REQ-008 SHALL have ports i_cmd_left_base, i_cmd_right_base  input  ADDR_WIDTH: first line index, left and right.
REQ-009 SHALL have port i_cmd_len  input  ADDR_WIDTH+1  line count, legal 1..BRAM_DEPTH.
REQ-010 SHALL have port i_abort  input  1  terminate the active command.
REQ-011 SHALL have ports o_man_left_rd_addr, o_man_right_rd_addr, o_exp_left_rd_addr, o_exp_right_rd_addr  output  ADDR_WIDTH each.
REQ-012 SHALL have ports o_man_left_rd_en, o_man_right_rd_en, o_exp_left_rd_en, o_exp_right_rd_en  output  1 each.
REQ-013 SHALL have ports i_man_left_rd_data, i_man_right_rd_data input MAN_WIDTH; i_exp_left_rd_data, i_exp_right_rd_data input EXP_WIDTH: registered tile-memory read data.
REQ-014 SHALL have ports o_valid output 1, i_ready input 1: beat handshake.
REQ-015 SHALL have ports o_man_left, o_man_right output MAN_WIDTH; o_exp_left, o_exp_right output EXP_WIDTH; o_last output 1: beat payload.
REQ-016 SHALL have ports o_busy, o_done, o_cmd_err  output  1 each: status.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; o_cmd_ready = 1 only in IDLE.
REQ-018 SHALL accept a command on the edge where i_cmd_valid && o_cmd_ready; legal length -> RUN; i_cmd_len==0 -> single-cycle o_cmd_err pulse, stay IDLE.
REQ-019 SHALL, in RUN, issue read k (k=0..len-1) by asserting all four rd_en in one cycle with left addr=(left_base+k) mod BRAM_DEPTH, right addr=(right_base+k) mod BRAM_DEPTH; exp addr equals mantissa addr per side.
REQ-020 SHALL issue a read only when reads remain and (!o_valid || i_ready); first issue no earlier than the cycle after command acceptance.
REQ-021 SHALL assert o_valid the cycle after each issue; payload outputs = tile read data directly; beat held stable (rd_en low) while o_valid && !i_ready.
REQ-022 SHALL sustain one beat per cycle with i_ready held high; read-to-valid latency exactly 1 cycle.
REQ-023 SHALL assert o_last with the beat for k=len-1 only.
REQ-024 SHALL, when the o_last beat transfers (o_valid && i_ready), pulse o_done one cycle and return to IDLE the next cycle; o_busy = (state==RUN).
REQ-025 SHALL, on i_abort in RUN, issue no further reads, drop o_valid next cycle, return to IDLE, and not pulse o_done; i_abort in IDLE is ignored; i_abort takes priority over a same-cycle transfer.
REQ-026 SHALL treat len==BRAM_DEPTH with nonzero base as full wrap, every line read once.

Reset
REQ-027 SHALL on i_reset_n low force asynchronously: state IDLE, o_valid/o_last/o_done/o_cmd_err/o_busy 0, all rd_en 0, addresses 0, counters 0.
REQ-028 SHALL abandon any in-flight command on reset without o_done; o_cmd_ready =1 from first edge after release.

Configuration
REQ-029 SHALL, with TILE_RD_RANGE_CHECK_EN defined, reject commands where base+len > BRAM_DEPTH on either side: o_cmd_err pulse, no reads, stay IDLE.
REQ-030 SHALL, without TILE_RD_RANGE_CHECK_EN, accept such commands and wrap addresses modulo BRAM_DEPTH.

Verification
REQ-031 SHALL cover: left_base=0,right_base=0,len=4, i_ready=1 -> addrs 0..3 on consecutive cycles, 4 beats, o_last on 4th, o_done 1 cycle after.
REQ-032 SHALL cover: len=3, i_ready low 2 cycles on beat 1 -> beat 1 data stable, rd_en low while stalled, 3 beats total in order.
REQ-033 SHALL cover: left_base=510,right_base=5,len=4, macro undefined -> left addrs 510,511,0,1; right 5..8; macro defined -> o_cmd_err, no rd_en.
REQ-034 SHALL cover: len=0 -> o_cmd_err one cycle, no rd_en, o_cmd_ready remains 1.
REQ-035 SHALL cover: len=8, i_abort after beat 2 -> no further rd_en, o_valid 0 next cycle, no o_done, next command accepted normally.
REQ-036 SHALL cover: i_reset_n low mid-RUN (len=16) -> all outputs 0 immediately, IDLE after release, no o_done.

Source files
------------

// File: rtl/tile_bram_reader.sv
// -----------------------------------------------------------------------------
// tile_bram_reader
//
// Purpose:
//   Streams a run of lines out of a pair of tile BRAM sides (left/right), each
//   side holding a mantissa memory and an exponent memory read at the same
//   address. A command supplies a base line per side and a line count. One read
//   is issued per cycle to all four memories. Each memory has a registered read
//   port, so its data is the beat payload on the following cycle. Under
//   back-pressure the reads pause, and the memories hold their last data, which
//   keeps the beat stable.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready   command handshake (ready only while idle)
//   i_cmd_left_base/right_base  first line index per side
//   i_cmd_len                   line count, legal 1..BRAM_DEPTH
//   i_abort                     terminate the active command
//   o_{man,exp}_{left,right}_rd_addr / _rd_en   tile memory read ports
//   i_{man,exp}_{left,right}_rd_data            registered tile memory data
//   o_valid / i_ready           beat handshake
//   o_man_*, o_exp_*, o_last    beat payload
//   o_busy, o_done, o_cmd_err   status
//
// Configuration:
//   TILE_RD_RANGE_CHECK_EN  when defined, a command whose base+len runs past
//                           BRAM_DEPTH on either side is rejected with
//                           o_cmd_err. When undefined, addresses wrap modulo
//                           BRAM_DEPTH.
// -----------------------------------------------------------------------------
module tile_bram_reader #(
    parameter int unsigned MAN_WIDTH  = 256,
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned BRAM_DEPTH = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_left_base,
    input  logic [ADDR_WIDTH-1:0] i_cmd_right_base,
    input  logic [ADDR_WIDTH:0]   i_cmd_len,
    input  logic                  i_abort,

    output logic [ADDR_WIDTH-1:0] o_man_left_rd_addr,
    output logic [ADDR_WIDTH-1:0] o_man_right_rd_addr,
    output logic [ADDR_WIDTH-1:0] o_exp_left_rd_addr,
    output logic [ADDR_WIDTH-1:0] o_exp_right_rd_addr,
    output logic                  o_man_left_rd_en,
    output logic                  o_man_right_rd_en,
    output logic                  o_exp_left_rd_en,
    output logic                  o_exp_right_rd_en,

    input  logic [MAN_WIDTH-1:0]  i_man_left_rd_data,
    input  logic [MAN_WIDTH-1:0]  i_man_right_rd_data,
    input  logic [EXP_WIDTH-1:0]  i_exp_left_rd_data,
    input  logic [EXP_WIDTH-1:0]  i_exp_right_rd_data,

    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [MAN_WIDTH-1:0]  o_man_left,
    output logic [MAN_WIDTH-1:0]  o_man_right,
    output logic [EXP_WIDTH-1:0]  o_exp_left,
    output logic [EXP_WIDTH-1:0]  o_exp_right,
    output logic                  o_last,

    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cmd_err
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]      LEN_MAX  = CNT_W'(BRAM_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] left_addr_q, left_addr_d;
    logic [ADDR_WIDTH-1:0] right_addr_q, right_addr_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  cmd_err_q, cmd_err_d;

    logic cmd_bad_c;
    logic reads_left_c;
    logic xfer_c;
    logic last_xfer_c;
    logic issue_c;

    // Command legality: zero or oversize length always illegal
`ifdef TILE_RD_RANGE_CHECK_EN
    localparam int unsigned RNG_W = ADDR_WIDTH + 2;
    logic [RNG_W-1:0] left_end_c;
    logic [RNG_W-1:0] right_end_c;

    assign left_end_c  = RNG_W'(i_cmd_left_base)  + RNG_W'(i_cmd_len);
    assign right_end_c = RNG_W'(i_cmd_right_base) + RNG_W'(i_cmd_len);
    assign cmd_bad_c   = (i_cmd_len == '0) || (i_cmd_len > LEN_MAX)
                       || (left_end_c  > RNG_W'(BRAM_DEPTH))
                       || (right_end_c > RNG_W'(BRAM_DEPTH));
`else
    assign cmd_bad_c   = (i_cmd_len == '0) || (i_cmd_len > LEN_MAX);
`endif

    // Handshake qualifiers; abort overrides a same-cycle transfer
    assign reads_left_c = (rd_cnt_q != len_q);
    assign xfer_c       = valid_q && i_ready;
    assign last_xfer_c  = (state_q == S_RUN) && !i_abort && xfer_c && last_q;
    assign issue_c      = (state_q == S_RUN) && !i_abort && reads_left_c
                        && (!valid_q || i_ready);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid && !cmd_bad_c) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort || last_xfer_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        left_addr_d  = left_addr_q;
        right_addr_d = right_addr_q;
        len_d        = len_q;
        rd_cnt_d     = rd_cnt_q;
        valid_d      = valid_q;
        last_d       = last_q;
        done_d       = 1'b0;
        cmd_err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (i_cmd_valid) begin
                    if (cmd_bad_c) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        left_addr_d  = i_cmd_left_base;
                        right_addr_d = i_cmd_right_base;
                        len_d        = i_cmd_len;
                        rd_cnt_d     = '0;
                    end
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (issue_c) begin
                    // New read replaces any beat consumed this cycle
                    valid_d      = 1'b1;
                    last_d       = (rd_cnt_q == (len_q - CNT_W'(1)));
                    rd_cnt_d     = rd_cnt_q + CNT_W'(1);
                    left_addr_d  = (left_addr_q == ADDR_MAX) ? '0
                                 : left_addr_q + ADDR_WIDTH'(1);
                    right_addr_d = (right_addr_q == ADDR_MAX) ? '0
                                 : right_addr_q + ADDR_WIDTH'(1);
                end else if (xfer_c) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                done_d = last_xfer_c;
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            left_addr_q  <= '0;
            right_addr_q <= '0;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            left_addr_q  <= left_addr_d;
            right_addr_q <= right_addr_d;
            len_q        <= len_d;
            rd_cnt_q     <= rd_cnt_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            done_q       <= done_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // Read enables must react to i_ready in the same cycle to keep one beat
    // per cycle; addresses come straight from the address registers.
    assign o_man_left_rd_en    = issue_c;
    assign o_man_right_rd_en   = issue_c;
    assign o_exp_left_rd_en    = issue_c;
    assign o_exp_right_rd_en   = issue_c;
    assign o_man_left_rd_addr  = left_addr_q;
    assign o_exp_left_rd_addr  = left_addr_q;
    assign o_man_right_rd_addr = right_addr_q;
    assign o_exp_right_rd_addr = right_addr_q;

    // Payload is the memories' own output register
    assign o_man_left  = i_man_left_rd_data;
    assign o_man_right = i_man_right_rd_data;
    assign o_exp_left  = i_exp_left_rd_data;
    assign o_exp_right = i_exp_right_rd_data;

    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_done      = done_q;
    assign o_cmd_err   = cmd_err_q;
    assign o_busy      = (state_q == S_RUN);
    assign o_cmd_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_tile_bram_reader.sv
// -----------------------------------------------------------------------------
// tb_tile_bram_reader
//
// Purpose: directed self-checking bench for tile_bram_reader. Models the four
// registered tile memories with address-derived data patterns and checks the
// read-address sequence, the beats, the handshakes and the status pulses.
// -----------------------------------------------------------------------------
module tb_tile_bram_reader;

    localparam int unsigned MW    = 256;
    localparam int unsigned EW    = 8;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_left_base;
    logic [AW-1:0] cmd_right_base;
    logic [AW:0]   cmd_len;
    logic          abort;
    logic [AW-1:0] ml_addr, mr_addr, el_addr, er_addr;
    logic          ml_en, mr_en, el_en, er_en;
    logic [MW-1:0] ml_data, mr_data;
    logic [EW-1:0] el_data, er_data;
    logic          valid, ready, last, busy, done, cmd_err;
    logic [MW-1:0] man_left, man_right;
    logic [EW-1:0] exp_left, exp_right;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_cmd
    int n_rd, n_beat, n_done, n_last;
    int rd_first, rd_last, vfirst, last_xfer, done_cyc;
    int q_l[$];
    int q_r[$];

    tile_bram_reader #(
        .MAN_WIDTH (MW),
        .EXP_WIDTH (EW),
        .BRAM_DEPTH(DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_cmd_valid        (cmd_valid),
        .o_cmd_ready        (cmd_ready),
        .i_cmd_left_base    (cmd_left_base),
        .i_cmd_right_base   (cmd_right_base),
        .i_cmd_len          (cmd_len),
        .i_abort            (abort),
        .o_man_left_rd_addr (ml_addr),
        .o_man_right_rd_addr(mr_addr),
        .o_exp_left_rd_addr (el_addr),
        .o_exp_right_rd_addr(er_addr),
        .o_man_left_rd_en   (ml_en),
        .o_man_right_rd_en  (mr_en),
        .o_exp_left_rd_en   (el_en),
        .o_exp_right_rd_en  (er_en),
        .i_man_left_rd_data (ml_data),
        .i_man_right_rd_data(mr_data),
        .i_exp_left_rd_data (el_data),
        .i_exp_right_rd_data(er_data),
        .o_valid            (valid),
        .i_ready            (ready),
        .o_man_left         (man_left),
        .o_man_right        (man_right),
        .o_exp_left         (exp_left),
        .o_exp_right        (exp_right),
        .o_last             (last),
        .o_busy             (busy),
        .o_done             (done),
        .o_cmd_err          (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MW-1:0] man_pat(input bit right, input int a);
        return right ? MW'(32'hBB00_0000 + 32'(a)) : MW'(32'hAA00_0000 + 32'(a));
    endfunction

    function automatic logic [EW-1:0] exp_pat(input bit right, input int a);
        return right ? EW'(a + 7) : (EW'(a) ^ 8'h3C);
    endfunction

    // Registered-read tile memories: output holds while enable is low
    always @(posedge clk) begin
        if (ml_en) ml_data <= man_pat(1'b0, int'(ml_addr));
        if (mr_en) mr_data <= man_pat(1'b1, int'(mr_addr));
        if (el_en) el_data <= exp_pat(1'b0, int'(el_addr));
        if (er_en) er_data <= exp_pat(1'b1, int'(er_addr));
    end

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one accepting edge; returns at edge+1 after it
    task automatic send_cmd(input int lb, input int rb, input int len);
        cmd_left_base  = AW'(lb);
        cmd_right_base = AW'(rb);
        cmd_len        = (AW+1)'(len);
        cmd_valid      = 1'b1;
        #1;
        chk("cmd_ready_idle", MW'(cmd_ready), MW'(1));
        tick();
        cmd_valid = 1'b0;
    endtask

    // Command expected to be rejected
    task automatic err_cmd(input int lb, input int rb, input int len);
        send_cmd(lb, rb, len);
        chk("err_pulse", MW'(cmd_err), MW'(1));
        chk("err_ready", MW'(cmd_ready), MW'(1));
        chk("err_busy", MW'(busy), MW'(0));
        chk("err_rd_en", MW'({ml_en, mr_en, el_en, er_en}), MW'(0));
        tick();
        chk("err_one_cycle", MW'(cmd_err), MW'(0));
        chk("err_no_rd", MW'({ml_en, mr_en, el_en, er_en}), MW'(0));
        chk("err_still_ready", MW'(cmd_ready), MW'(1));
    endtask

    // Send a command and follow it to completion. stall_at: beat index held
    // for stall_n cycles (-1 none); abort_at: abort once that many beats moved.
    task automatic run_cmd(input int lb, input int rb, input int len,
                           input int stall_at, input int stall_n, input int abort_at);
        int  cyc;
        int  stalled;
        int  abort_cyc;
        bit  aborted;
        bit  any_rd;
        int  ea_l;
        int  ea_r;
        n_rd = 0; n_beat = 0; n_done = 0; n_last = 0;
        rd_first = -1; rd_last = -1; vfirst = -1; last_xfer = -1; done_cyc = -1;
        q_l.delete();
        q_r.delete();
        cyc = 0; stalled = 0; abort_cyc = -10; aborted = 1'b0;
        send_cmd(lb, rb, len);
        forever begin
            ready = 1'b1;
            abort = 1'b0;
            if (valid && n_beat == stall_at && stalled < stall_n) begin
                ready = 1'b0;
                stalled++;
            end
            if (!aborted && abort_at >= 0 && n_beat == abort_at) begin
                abort     = 1'b1;
                aborted   = 1'b1;
                abort_cyc = cyc;
            end
            #1;
            any_rd = ml_en | mr_en | el_en | er_en;
            if (any_rd) begin
                ea_l = (lb + n_rd) % DEPTH;
                ea_r = (rb + n_rd) % DEPTH;
                chk("rd_en_all4", MW'({ml_en, mr_en, el_en, er_en}), MW'(4'hF));
                chk("man_left_addr", MW'(ml_addr), MW'(ea_l));
                chk("exp_left_addr", MW'(el_addr), MW'(ea_l));
                chk("man_right_addr", MW'(mr_addr), MW'(ea_r));
                chk("exp_right_addr", MW'(er_addr), MW'(ea_r));
                q_l.push_back(int'(ml_addr));
                q_r.push_back(int'(mr_addr));
                if (n_rd == 0) rd_first = cyc;
                rd_last = cyc;
                n_rd++;
            end
            if (aborted) chk("rd_en_after_abort", MW'(any_rd), MW'(0));
            if (valid && vfirst < 0) vfirst = cyc;
            if (valid && !ready) begin
                chk("rd_en_while_stalled", MW'(any_rd), MW'(0));
                chk("stall_man_left", man_left, man_pat(1'b0, (lb + n_beat) % DEPTH));
                chk("stall_exp_right", MW'(exp_right), MW'(exp_pat(1'b1, (rb + n_beat) % DEPTH)));
            end
            if (valid && ready && !abort) begin
                ea_l = (lb + n_beat) % DEPTH;
                ea_r = (rb + n_beat) % DEPTH;
                chk("beat_man_left", man_left, man_pat(1'b0, ea_l));
                chk("beat_man_right", man_right, man_pat(1'b1, ea_r));
                chk("beat_exp_left", MW'(exp_left), MW'(exp_pat(1'b0, ea_l)));
                chk("beat_exp_right", MW'(exp_right), MW'(exp_pat(1'b1, ea_r)));
                chk("beat_last", MW'(last), MW'(n_beat == len - 1));
                if (last) begin
                    n_last++;
                    last_xfer = cyc;
                end
                n_beat++;
            end
            if (aborted && cyc == abort_cyc + 1) chk("valid_after_abort", MW'(valid), MW'(0));
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (!busy) break;
            cyc++;
            if (cyc > len * 4 + 40) begin
                chk("run_timeout", MW'(cyc), MW'(0));
                break;
            end
            tick();
        end
        ready = 1'b1;
        abort = 1'b0;
    endtask

    // Overall time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_left_base  = '0;
        cmd_right_base = '0;
        cmd_len        = '0;
        abort          = 1'b0;
        ready          = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", MW'(valid), MW'(0));
        chk("rst_last", MW'(last), MW'(0));
        chk("rst_done", MW'(done), MW'(0));
        chk("rst_cmd_err", MW'(cmd_err), MW'(0));
        chk("rst_busy", MW'(busy), MW'(0));
        chk("rst_rd_en", MW'({ml_en, mr_en, el_en, er_en}), MW'(0));
        chk("rst_addrs", MW'({ml_addr, mr_addr, el_addr, er_addr}), MW'(0));
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", MW'(cmd_ready), MW'(1));

        // Basic streaming: bases 0/0, len 4, ready high
        run_cmd(0, 0, 4, -1, 0, -1);
        chk("t1_reads", MW'(n_rd), MW'(4));
        chk("t1_beats", MW'(n_beat), MW'(4));
        chk("t1_last_count", MW'(n_last), MW'(1));
        chk("t1_done_count", MW'(n_done), MW'(1));
        chk("t1_first_rd_cycle", MW'(rd_first), MW'(0));
        chk("t1_rd_span", MW'(rd_last - rd_first), MW'(3));
        chk("t1_rd_to_valid", MW'(vfirst - rd_first), MW'(1));
        chk("t1_done_after_last", MW'(done_cyc - last_xfer), MW'(1));
        tick();
        chk("t1_done_pulse_ends", MW'(done), MW'(0));
        chk("t1_ready_again", MW'(cmd_ready), MW'(1));

        // Back-pressure: beat 1 held for two cycles
        run_cmd(20, 40, 3, 1, 2, -1);
        chk("t2_reads", MW'(n_rd), MW'(3));
        chk("t2_beats", MW'(n_beat), MW'(3));
        chk("t2_rd_span", MW'(rd_last - rd_first), MW'(4));
        chk("t2_done_count", MW'(n_done), MW'(1));
        tick();

        // Range across the end of the left memory
`ifdef TILE_RD_RANGE_CHECK_EN
        err_cmd(510, 5, 4);
`else
        run_cmd(510, 5, 4, -1, 0, -1);
        chk("t3_reads", MW'(n_rd), MW'(4));
        if (q_l.size() == 4 && q_r.size() == 4) begin
            chk("t3_left0", MW'(q_l[0]), MW'(510));
            chk("t3_left1", MW'(q_l[1]), MW'(511));
            chk("t3_left2", MW'(q_l[2]), MW'(0));
            chk("t3_left3", MW'(q_l[3]), MW'(1));
            chk("t3_right0", MW'(q_r[0]), MW'(5));
            chk("t3_right3", MW'(q_r[3]), MW'(8));
        end
        chk("t3_done_count", MW'(n_done), MW'(1));
        tick();
`endif

        // Zero length
        err_cmd(3, 3, 0);

        // Abort after two beats, then a normal command
        run_cmd(100, 200, 8, -1, 0, 2);
        chk("t5_reads", MW'(n_rd), MW'(3));
        chk("t5_beats", MW'(n_beat), MW'(2));
        chk("t5_no_done", MW'(n_done), MW'(0));
        tick();
        chk("t5_no_late_done", MW'(done), MW'(0));
        chk("t5_idle", MW'(cmd_ready), MW'(1));
        run_cmd(7, 9, 2, -1, 0, -1);
        chk("t5b_beats", MW'(n_beat), MW'(2));
        chk("t5b_done_count", MW'(n_done), MW'(1));
        tick();

        // Abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ready", MW'(cmd_ready), MW'(1));
        chk("idle_abort_busy", MW'(busy), MW'(0));

        // Full-depth run from a nonzero base
`ifdef TILE_RD_RANGE_CHECK_EN
        err_cmd(100, 0, 512);
`else
        run_cmd(100, 300, 512, -1, 0, -1);
        chk("t6_reads", MW'(n_rd), MW'(512));
        chk("t6_beats", MW'(n_beat), MW'(512));
        chk("t6_done_count", MW'(n_done), MW'(1));
        if (q_l.size() == 512) begin
            chk("t6_left_wrap_at_412", MW'(q_l[412]), MW'(0));
            chk("t6_left_final", MW'(q_l[511]), MW'(99));
        end
        tick();
`endif

        // Reset in the middle of a long command
        send_cmd(0, 0, 16);
        repeat (5) tick();
        chk("t7_busy_before_rst", MW'(busy), MW'(1));
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", MW'(valid), MW'(0));
        chk("t7_rst_last", MW'(last), MW'(0));
        chk("t7_rst_busy", MW'(busy), MW'(0));
        chk("t7_rst_done", MW'(done), MW'(0));
        chk("t7_rst_err", MW'(cmd_err), MW'(0));
        chk("t7_rst_rd_en", MW'({ml_en, mr_en, el_en, er_en}), MW'(0));
        chk("t7_rst_addrs", MW'({ml_addr, mr_addr, el_addr, er_addr}), MW'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t7_ready_after", MW'(cmd_ready), MW'(1));
        chk("t7_busy_after", MW'(busy), MW'(0));
        chk("t7_no_done", MW'(done), MW'(0));
        tick();
        chk("t7_no_done_late", MW'(done), MW'(0));
        chk("t7_no_valid", MW'(valid), MW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
